// File: rtl/serial_alu_seq.sv
// Bit-serial ALU (AND/OR/XOR/NOR/ADD/SUB) processing one operand bit per cycle, LSB first.
// Latency: done pulses WIDTH+1 cycles after start is sampled in IDLE; one op in flight at a time.
// Backpressure: none; start is only honoured in IDLE (busy low), requests in RUN/DONE are dropped.
// Build option: define SERIAL_ALU_OVF_EN to expose the signed-overflow flag on output port ovf.

module serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             less,
  output logic             zero
`ifdef SERIAL_ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  // Captured operation; operands shift right so bit 0 is always the current bit.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [2:0]       op_q;
  logic             sub_q;
  logic             carry;
  logic [CW-1:0]    bit_cnt;

  // Result fills from the MSB end so that after WIDTH shifts it is aligned.
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             less_q;
  logic             zero_q;

  logic             accept;
  logic             last_bit;
  logic             is_arith;
  logic             a_bit;
  logic             b_eff;
  logic             res_bit;
  logic             carry_nxt;
  logic             ovf_int;
  logic [WIDTH-1:0] result_nxt;

  assign accept   = (state == IDLE) && start;
  assign last_bit = (bit_cnt == CW'(WIDTH - 1));
  assign is_arith = (op_q == OP_ADD);

  // State register; reset wins over any pending start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // One-bit slice of the ALU; the adder's B input is inverted for subtract.
  always_comb begin
    a_bit     = a_sh[0];
    b_eff     = b_sh[0] ^ sub_q;
    carry_nxt = (a_bit & b_eff) | (a_bit & carry) | (b_eff & carry);
    res_bit   = 1'b0;
    case (op_q)
      OP_AND:  res_bit = a_bit & b_sh[0];
      OP_OR:   res_bit = a_bit | b_sh[0];
      OP_XOR:  res_bit = a_bit ^ b_sh[0];
      OP_NOR:  res_bit = ~(a_bit | b_sh[0]);
      OP_ADD:  res_bit = a_bit ^ b_eff ^ carry;
      default: res_bit = 1'b0;
    endcase
    // On the MSB cycle 'carry' is the carry into the MSB, carry_nxt the carry out.
    ovf_int    = carry ^ carry_nxt;
    result_nxt = {res_bit, result_q[WIDTH-1:1]};
  end

  // Operand capture, bit-serial datapath and flag registration on the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      op_q     <= '0;
      sub_q    <= 1'b0;
      carry    <= 1'b0;
      bit_cnt  <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      less_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= b;
      op_q    <= op;
      sub_q   <= sub;
      carry   <= sub;
      bit_cnt <= '0;
    end else if (state == RUN) begin
      a_sh     <= a_sh >> 1;
      b_sh     <= b_sh >> 1;
      carry    <= carry_nxt;
      bit_cnt  <= bit_cnt + CW'(1);
      result_q <= result_nxt;
      if (last_bit) begin
        cout_q <= is_arith & carry_nxt;
        less_q <= is_arith & sub_q & (res_bit ^ ovf_int);
        zero_q <= (result_nxt == '0);
      end
    end
  end

`ifdef SERIAL_ALU_OVF_EN
  logic ovf_q;

  // Overflow flag, latched alongside the other flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if ((state == RUN) && last_bit) begin
      ovf_q <= is_arith & ovf_int;
    end
  end

  assign ovf = ovf_q;
`endif

  assign result = result_q;
  assign cout   = cout_q;
  assign less   = less_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Randomized bench for serial_alu_seq against an arithmetic reference model.
// Latency: checks done arrives WIDTH+1 cycles after the start cycle.
// Backpressure: exercises ignored start during RUN, reset mid-op and reset/start collision.

module tb_serial_alu_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         less;
  logic         zero;
`ifdef SERIAL_ALU_OVF_EN
  logic         ovf;
`endif

  int vectors    = 0;
  int miscompares = 0;

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .less   (less),
    .zero   (zero)
`ifdef SERIAL_ALU_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic, signed comparisons done on sign-extended integers.
  function automatic void model(input logic [2:0] o, input logic s,
                                input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic c,
                                output logic l, output logic v, output logic z);
    longint ux;
    longint uy;
    longint sx;
    longint sy;
    longint full;
    longint exact;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    c = 1'b0;
    l = 1'b0;
    v = 1'b0;
    case (o)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b010: r = x ^ y;
      3'b011: r = ~(x | y);
      3'b100: begin
        if (s) begin
          full  = ux - uy;
          exact = sx - sy;
          c     = (ux >= uy);
          l     = (sx < sy);
        end else begin
          full  = ux + uy;
          exact = sx + sy;
          c     = (full >= (longint'(1) <<< W));
        end
        r = full[W-1:0];
        v = (exact > ((longint'(1) <<< (W - 1)) - 1)) || (exact < -(longint'(1) <<< (W - 1)));
      end
      default: r = '0;
    endcase
    z = (r == '0);
  endfunction

  // Issue one operation; restart_cyc > 0 pulses start again in that RUN cycle.
  task automatic run_op(input logic [2:0] o, input logic s, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int restart_cyc);
    logic [W-1:0] er;
    logic ec, el, ev, ez;
    int cyc;
    int extra;
    model(o, s, x, y, er, ec, el, ev, ez);
    @(negedge clk);
    start = 1'b1; op = o; sub = s; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 3'($urandom); sub = 1'($urandom);
    cyc = 1;
    check("busy_run", 32'(busy), 32'd1);
    while (!done && cyc < 3 * W) begin
      start = (cyc == restart_cyc);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("latency", 32'(cyc), 32'(W + 1));
    check("result", 32'(result), 32'(er));
    check("cout", 32'(cout), 32'(ec));
    check("less", 32'(less), 32'(el));
    check("zero", 32'(zero), 32'(ez));
`ifdef SERIAL_ALU_OVF_EN
    check("ovf", 32'(ovf), 32'(ev));
`endif
    check("busy_done", 32'(busy), 32'd0);
    extra = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("extra_done", 32'(extra), 32'd0);
    check("hold_result", 32'(result), 32'(er));
    check("hold_zero", 32'(zero), 32'(ez));
  endtask

  // Start an op, then reset it in RUN cycle 4; expect clean abort.
  task automatic reset_mid_op(input logic [W-1:0] x, input logic [W-1:0] y);
    int dones;
    @(negedge clk);
    start = 1'b1; op = 3'b100; sub = 1'b0; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", {29'd0, cout, less, zero}, 32'd0);
`ifdef SERIAL_ALU_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    dones = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("rst_no_done", 32'(dones), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_flags", {29'd0, cout, less, zero}, 32'd0);
`ifdef SERIAL_ALU_OVF_EN
    check("reset_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;

    run_op(3'b100, 1'b0, 8'h7F, 8'h01, 0);
    run_op(3'b100, 1'b1, 8'h05, 8'h07, 0);
    run_op(3'b100, 1'b1, 8'h80, 8'h01, 0);
    run_op(3'b011, 1'b0, 8'h0F, 8'hF0, 0);
    run_op(3'b101, 1'b0, 8'h0F, 8'hF0, 0);
    run_op(3'b010, 1'b0, 8'h3C, 8'h5A, 3);
    reset_mid_op(8'h12, 8'h34);

    // Reset and start together: reset must win.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op = 3'b100; a = 8'h11; b = 8'h22;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_vs_start", 32'(busy), 32'd0);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), 1'($urandom), W'($urandom), W'($urandom),
             (i % 5 == 0) ? int'($urandom_range(1, W - 1)) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
